el2_lsu_ecc_mb: RTL and testbench

//  Multi-bank DCCM SEC-DED checker/corrector with a registered decode stage and a correction write-back queue.
//  Per bank: encodes store data, checks read data, corrects single-bit errors, flags double-bit errors.

---
 rtl/el2_pkg.sv | 18 +
 rtl/el2_lsu_ecc_bank.sv | 86 ++++++++
 rtl/el2_lsu_ecc_mb.sv | 197 +++++++++++++++++++
 tb/tb_el2_lsu_ecc_mb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared helpers for the multi-bank DCCM SEC-DED checker (el2_lsu_ecc_mb).
//   ecc_width(data_w) : check-bit count for a bank of data_w bits
//                       (Hamming bits plus one overall-parity bit)
//   popcnt(v)         : number of set bits in an up-to-8-bit bank mask
package el2_pkg;

    function automatic int ecc_width(input int data_w);
        return $clog2(data_w) + 2;
    endfunction

    function automatic int popcnt(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/el2_lsu_ecc_bank.sv
// One DCCM bank of SEC-DED logic, purely combinational.
// Codeword layout: positions 1..DATA_W+HAM_W, powers of two hold the Hamming
// bits, data bits fill the remaining positions in ascending order. The top
// check bit is the overall parity of data plus Hamming bits.
// Ports:
//   i_dec_en   : decode enabled (bank participates and ECC is not disabled)
//   i_rd_data  : raw read data       i_rd_ecc : stored check bits
//   o_sec_data : corrected data      o_single / o_double : error flags
//   i_wr_data  : store data          o_wr_ecc : its check bits
//   i_wb_data  : corrected line data o_wb_ecc : its re-encoded check bits
module el2_lsu_ecc_bank #(
    parameter int DATA_W = 32,
    parameter int ECC_W  = 7
) (
    input  logic              i_dec_en,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic [ECC_W-1:0]  i_rd_ecc,
    output logic [DATA_W-1:0] o_sec_data,
    output logic              o_single,
    output logic              o_double,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [ECC_W-1:0]  o_wr_ecc,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [ECC_W-1:0]  o_wb_ecc
);
    localparam int HAM_W = ECC_W - 1;

    // Codeword position of data bit idx (skips power-of-two positions).
    function automatic int f_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= DATA_W + ECC_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [HAM_W-1:0] f_ham(input logic [DATA_W-1:0] d);
        logic [HAM_W-1:0] h;
        int               pos;
        h = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pos = f_pos(i);
            for (int k = 0; k < HAM_W; k++)
                if (pos[k] && d[i]) h[k] = ~h[k];
        end
        return h;
    endfunction

    function automatic logic [ECC_W-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [HAM_W-1:0] h;
        h = f_ham(d);
        return {^{d, h}, h};
    endfunction

    logic [HAM_W-1:0] w_syn;
    logic             w_par;

    assign w_syn    = f_ham(i_rd_data) ^ i_rd_ecc[HAM_W-1:0];
    assign w_par    = ^{i_rd_data, i_rd_ecc};
    assign o_wr_ecc = f_encode(i_wr_data);
    assign o_wb_ecc = f_encode(i_wb_data);

    // A syndrome naming a check-bit position matches no data bit, so the
    // data passes through unchanged but is still reported as corrected.
    always_comb begin
        o_sec_data = i_rd_data;
        o_single   = 1'b0;
        o_double   = 1'b0;
        if (i_dec_en && (w_syn != '0)) begin
            if (w_par) begin
                o_single = 1'b1;
                for (int i = 0; i < DATA_W; i++)
                    if (f_pos(i) == int'(w_syn)) o_sec_data[i] = ~i_rd_data[i];
            end else begin
                o_double = 1'b1;
            end
        end
    end

endmodule

// File: rtl/el2_lsu_ecc_mb.sv
// Multi-bank DCCM SEC-DED checker/corrector with a registered decode stage,
// a write-back queue of corrected lines and saturating SEC/DED counters.
// Optional macro EL2_LSU_ECC_ERR_INJECT_EN adds inj_en_i / inj_mask_i inputs
// and a wr_data_o output; the mask ({data,ecc} per bank) is XORed into the
// store encode path only, never into the write-back path.
// Ports: read side rd_*_i -> rd_valid_o/sec_data_o/single_err_o/double_err_o
// (one cycle later); store side wr_data_i -> wr_ecc_o (combinational);
// write-back wb_* head of queue popped by wb_gnt_i; counters sec/ded_cnt_o,
// cleared with wb_ovf_o by cnt_clr_i.
module el2_lsu_ecc_mb
    import el2_pkg::*;
#(
    parameter int  NUM_BANKS = 2,
    parameter int  DATA_W    = 32,
    parameter int  ADDR_W    = 16,
    parameter int  WB_DEPTH  = 4,
    parameter int  CNT_W     = 16,
    localparam int ECC_W     = ecc_width(DATA_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ecc_disable,
    input  logic                        rd_valid_i,
    input  logic [NUM_BANKS-1:0]        rd_bank_en_i,
    input  logic [ADDR_W-1:0]           rd_addr_i,
    input  logic [NUM_BANKS*DATA_W-1:0] rd_data_i,
    input  logic [NUM_BANKS*ECC_W-1:0]  rd_ecc_i,
    output logic                        rd_valid_o,
    output logic [NUM_BANKS*DATA_W-1:0] sec_data_o,
    output logic [NUM_BANKS-1:0]        single_err_o,
    output logic [NUM_BANKS-1:0]        double_err_o,
    input  logic [NUM_BANKS*DATA_W-1:0] wr_data_i,
`ifdef EL2_LSU_ECC_ERR_INJECT_EN
    input  logic                                 inj_en_i,
    input  logic [NUM_BANKS*(DATA_W+ECC_W)-1:0]  inj_mask_i,
    output logic [NUM_BANKS*DATA_W-1:0]          wr_data_o,
`endif
    output logic [NUM_BANKS*ECC_W-1:0]  wr_ecc_o,
    output logic                        wb_req_o,
    input  logic                        wb_gnt_i,
    output logic [ADDR_W-1:0]           wb_addr_o,
    output logic [NUM_BANKS-1:0]        wb_be_o,
    output logic [NUM_BANKS*DATA_W-1:0] wb_data_o,
    output logic [NUM_BANKS*ECC_W-1:0]  wb_ecc_o,
    output logic                        wb_full_o,
    output logic                        wb_ovf_o,
    input  logic                        cnt_clr_i,
    output logic [CNT_W-1:0]            sec_cnt_o,
    output logic [CNT_W-1:0]            ded_cnt_o
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int SUM_W = CNT_W + 4;

    typedef struct packed {
        logic [ADDR_W-1:0]           addr;
        logic [NUM_BANKS-1:0]        be;
        logic [NUM_BANKS*DATA_W-1:0] data;
        logic [NUM_BANKS*ECC_W-1:0]  ecc;
    } el2_ecc_wb_pkt_t;

    logic [NUM_BANKS*DATA_W-1:0] w_sec_data;
    logic [NUM_BANKS-1:0]        w_single;
    logic [NUM_BANKS-1:0]        w_double;
    logic [NUM_BANKS*ECC_W-1:0]  w_wr_ecc;
    logic [NUM_BANKS*ECC_W-1:0]  w_wb_ecc;

    logic                        r_rd_valid;
    logic [NUM_BANKS*DATA_W-1:0] r_sec_data;
    logic [NUM_BANKS-1:0]        r_single;
    logic [NUM_BANKS-1:0]        r_double;
    logic [ADDR_W-1:0]           r_addr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        el2_lsu_ecc_bank #(.DATA_W(DATA_W), .ECC_W(ECC_W)) u_bank (
            .i_dec_en   (rd_bank_en_i[b] & ~ecc_disable),
            .i_rd_data  (rd_data_i[b*DATA_W +: DATA_W]),
            .i_rd_ecc   (rd_ecc_i[b*ECC_W +: ECC_W]),
            .o_sec_data (w_sec_data[b*DATA_W +: DATA_W]),
            .o_single   (w_single[b]),
            .o_double   (w_double[b]),
            .i_wr_data  (wr_data_i[b*DATA_W +: DATA_W]),
            .o_wr_ecc   (w_wr_ecc[b*ECC_W +: ECC_W]),
            .i_wb_data  (r_sec_data[b*DATA_W +: DATA_W]),
            .o_wb_ecc   (w_wb_ecc[b*ECC_W +: ECC_W])
        );
    end

`ifdef EL2_LSU_ECC_ERR_INJECT_EN
    always_comb begin
        wr_data_o = wr_data_i;
        wr_ecc_o  = w_wr_ecc;
        if (inj_en_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                wr_data_o[b*DATA_W +: DATA_W] ^= inj_mask_i[b*(DATA_W+ECC_W)+ECC_W +: DATA_W];
                wr_ecc_o[b*ECC_W +: ECC_W]    ^= inj_mask_i[b*(DATA_W+ECC_W) +: ECC_W];
            end
        end
    end
`else
    assign wr_ecc_o = w_wr_ecc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_sec_data <= '0;
            r_single   <= '0;
            r_double   <= '0;
            r_addr     <= '0;
        end else begin
            r_rd_valid <= rd_valid_i;
            r_single   <= rd_valid_i ? w_single : '0;
            r_double   <= rd_valid_i ? w_double : '0;
            if (rd_valid_i) begin
                r_sec_data <= w_sec_data;
                r_addr     <= rd_addr_i;
            end
        end
    end

    assign rd_valid_o   = r_rd_valid;
    assign sec_data_o   = r_sec_data;
    assign single_err_o = r_single;
    assign double_err_o = r_double;

    // Write-back queue
    el2_ecc_wb_pkt_t r_mem [WB_DEPTH];
    el2_ecc_wb_pkt_t w_head;
    el2_ecc_wb_pkt_t w_new_pkt;
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push, w_pop, w_full, w_drop, w_accept;

    assign w_push    = r_rd_valid & (|r_single) & ~(|r_double);
    assign w_full    = (r_count == (PTR_W+1)'(WB_DEPTH));
    assign w_pop     = wb_req_o & wb_gnt_i;
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_accept  = w_push & ~w_drop;
    assign w_new_pkt = '{addr: r_addr, be: r_single, data: r_sec_data, ecc: w_wb_ecc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)    r_rptr <= r_rptr + PTR_W'(1);
            if (w_accept && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (!w_accept && w_pop) r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Storage is qualified by r_count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= w_new_pkt;
    end

    assign w_head    = r_mem[r_rptr];
    assign wb_req_o  = (r_count != '0);
    assign wb_full_o = w_full;
    assign wb_addr_o = w_head.addr;
    assign wb_be_o   = w_head.be;
    assign wb_data_o = w_head.data;
    assign wb_ecc_o  = w_head.ecc;

    // Counters and overflow flag
    logic [SUM_W-1:0] w_sec_sum, w_ded_sum;
    logic [CNT_W-1:0] r_sec_cnt, r_ded_cnt;
    logic             r_ovf;

    assign w_sec_sum = SUM_W'(r_sec_cnt) + SUM_W'(popcnt(8'(r_single)));
    assign w_ded_sum = SUM_W'(r_ded_cnt) + SUM_W'(popcnt(8'(r_double)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (cnt_clr_i) begin
                r_sec_cnt <= '0;
                r_ded_cnt <= '0;
            end else begin
                r_sec_cnt <= (|w_sec_sum[SUM_W-1:CNT_W]) ? '1 : w_sec_sum[CNT_W-1:0];
                r_ded_cnt <= (|w_ded_sum[SUM_W-1:CNT_W]) ? '1 : w_ded_sum[CNT_W-1:0];
            end
            if (w_drop)         r_ovf <= 1'b1;
            else if (cnt_clr_i) r_ovf <= 1'b0;
        end
    end

    assign sec_cnt_o = r_sec_cnt;
    assign ded_cnt_o = r_ded_cnt;
    assign wb_ovf_o  = r_ovf;

endmodule

// File: tb/tb_el2_lsu_ecc_mb.sv
module tb_el2_lsu_ecc_mb;
    localparam int NB = 2, DW = 32, EW = 7, AW = 16, DEPTH = 4, CW = 4;

    logic              clk, rst, ecc_disable, rd_valid_i, rd_valid_o;
    logic [NB-1:0]     rd_bank_en_i, single_err_o, double_err_o, wb_be_o;
    logic [AW-1:0]     rd_addr_i, wb_addr_o;
    logic [NB*DW-1:0]  rd_data_i, sec_data_o, wr_data_i, wb_data_o;
    logic [NB*EW-1:0]  rd_ecc_i, wr_ecc_o, wb_ecc_o;
    logic              wb_req_o, wb_gnt_i, wb_full_o, wb_ovf_o, cnt_clr_i;
    logic [CW-1:0]     sec_cnt_o, ded_cnt_o;
`ifdef EL2_LSU_ECC_ERR_INJECT_EN
    logic                  inj_en_i;
    logic [NB*(DW+EW)-1:0] inj_mask_i;
    logic [NB*DW-1:0]      wr_data_o;
`endif

    el2_lsu_ecc_mb #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ecc_disable(ecc_disable),
        .rd_valid_i(rd_valid_i), .rd_bank_en_i(rd_bank_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_i(rd_data_i), .rd_ecc_i(rd_ecc_i), .rd_valid_o(rd_valid_o),
        .sec_data_o(sec_data_o), .single_err_o(single_err_o), .double_err_o(double_err_o),
        .wr_data_i(wr_data_i),
`ifdef EL2_LSU_ECC_ERR_INJECT_EN
        .inj_en_i(inj_en_i), .inj_mask_i(inj_mask_i), .wr_data_o(wr_data_o),
`endif
        .wr_ecc_o(wr_ecc_o), .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i),
        .wb_addr_o(wb_addr_o), .wb_be_o(wb_be_o), .wb_data_o(wb_data_o), .wb_ecc_o(wb_ecc_o),
        .wb_full_o(wb_full_o), .wb_ovf_o(wb_ovf_o), .cnt_clr_i(cnt_clr_i),
        .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int dpos [DW];

    // Reference code: check bits = XOR of the codeword positions of all set
    // data bits, so a valid codeword has a zero position-XOR.
    function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
        logic [EW-2:0] s;
        s = '0;
        for (int i = 0; i < DW; i++) if (d[i]) s ^= 6'(dpos[i]);
        return {(^d) ^ (^s), s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // stimulus: true data per bank plus flip masks applied on the way in
    logic          s_valid, s_dis, gnt, clr;
    logic [NB-1:0] s_en;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_d [NB];
    logic [DW-1:0] f_d [NB];
    logic [EW-1:0] f_e [NB];
    logic [NB*DW-1:0] s_wr;

    // reference state
    typedef struct { logic [AW-1:0] addr; logic [NB-1:0] be; logic [NB*DW-1:0] data; logic [NB*EW-1:0] ecc; } ent_t;
    ent_t q[$];
    logic          m_valid, m_ovf;
    logic [NB*DW-1:0] m_data;
    logic [NB-1:0] m_single, m_double;
    logic [AW-1:0] m_addr;
    int            m_sec, m_ded;

    task automatic model_reset();
        q.delete();
        m_valid = 0; m_ovf = 0; m_data = '0; m_single = '0; m_double = '0;
        m_addr = '0; m_sec = 0; m_ded = 0;
    endtask

    task automatic clear_stim();
        s_valid = 0; s_dis = 0; gnt = 0; clr = 0; s_en = 2'b11; s_addr = '0;
        for (int b = 0; b < NB; b++) begin f_d[b] = '0; f_e[b] = '0; end
    endtask

    task automatic drive();
        rd_valid_i = s_valid; rd_bank_en_i = s_en; rd_addr_i = s_addr; ecc_disable = s_dis;
        for (int b = 0; b < NB; b++) begin
            rd_data_i[b*DW +: DW] = s_d[b] ^ f_d[b];
            rd_ecc_i[b*EW +: EW]  = enc(s_d[b]) ^ f_e[b];
        end
        wb_gnt_i = gnt; cnt_clr_i = clr; wr_data_i = s_wr;
    endtask

    task automatic check_all();
        chk("rd_valid", 64'(rd_valid_o), 64'(m_valid));
        if (m_valid) chk("sec_data", sec_data_o, m_data);
        chk("single_err", 64'(single_err_o), 64'(m_single));
        chk("double_err", 64'(double_err_o), 64'(m_double));
        chk("wb_req", 64'(wb_req_o), 64'(q.size() != 0));
        chk("wb_full", 64'(wb_full_o), 64'(q.size() == DEPTH));
        chk("wb_ovf", 64'(wb_ovf_o), 64'(m_ovf));
        chk("sec_cnt", 64'(sec_cnt_o), 64'(m_sec));
        chk("ded_cnt", 64'(ded_cnt_o), 64'(m_ded));
        if (q.size() != 0) begin
            chk("wb_addr", 64'(wb_addr_o), 64'(q[0].addr));
            chk("wb_be", 64'(wb_be_o), 64'(q[0].be));
            chk("wb_data", wb_data_o, q[0].data);
            chk("wb_ecc", 64'(wb_ecc_o), 64'(q[0].ecc));
        end
        chk("wr_ecc", 64'(wr_ecc_o), 64'({enc(s_wr[DW +: DW]), enc(s_wr[0 +: DW])}));
`ifdef EL2_LSU_ECC_ERR_INJECT_EN
        chk("wr_data", wr_data_o, s_wr);
`endif
    endtask

    // What the coming clock edge does, from the behavioural rules.
    task automatic model_update();
        ent_t e;
        bit push, pop, drop;
        int tot;
        e.addr = m_addr; e.be = m_single; e.data = m_data;
        e.ecc = {enc(m_data[DW +: DW]), enc(m_data[0 +: DW])};
        push = m_valid && (m_single != 0) && (m_double == 0);
        pop  = (q.size() != 0) && gnt;
        drop = push && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(e);
        if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
        if (clr) begin m_sec = 0; m_ded = 0; end
        else begin
            m_sec = (m_sec + $countones(m_single) > 15) ? 15 : m_sec + $countones(m_single);
            m_ded = (m_ded + $countones(m_double) > 15) ? 15 : m_ded + $countones(m_double);
        end
        m_valid = s_valid; m_single = '0; m_double = '0;
        if (s_valid) begin
            m_addr = s_addr;
            for (int b = 0; b < NB; b++) begin
                tot = $countones(f_d[b]) + $countones(f_e[b]);
                m_data[b*DW +: DW] = s_d[b] ^ f_d[b];
                if (s_en[b] && !s_dis && tot == 1 && !f_e[b][EW-1]) begin
                    m_single[b] = 1'b1;
                    m_data[b*DW +: DW] = s_d[b];
                end else if (s_en[b] && !s_dis && tot == 2) begin
                    m_double[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
        s_wr = {$urandom, $urandom};
    endtask

    task automatic set_flips(input int b, input int n);
        logic [DW+EW-1:0] v;
        int idx;
        v = '0;
        for (int k = 0; k < n; k++) begin
            idx = int'($urandom_range(DW+EW-1, 0));
            while (v[idx]) idx = int'($urandom_range(DW+EW-1, 0));
            v[idx] = 1'b1;
        end
        f_d[b] = v[DW-1:0];
        f_e[b] = v[DW+EW-1:DW];
    endtask

    // a line with exactly one data-bit error in bank b, other bank clean
    task automatic sread(input int b);
        clear_stim();
        s_valid = 1; s_en = 2'b11; s_addr = AW'($urandom);
        s_d[0] = $urandom; s_d[1] = $urandom;
        f_d[b] = 32'h1 << $urandom_range(31, 0);
    endtask

    initial begin
        begin
            int p = 1;
            for (int i = 0; i < DW; i++) begin
                while ((p & (p - 1)) == 0) p++;
                dpos[i] = p;
                p++;
            end
        end
        s_d[0] = '0; s_d[1] = '0; s_wr = '0;
`ifdef EL2_LSU_ECC_ERR_INJECT_EN
        inj_en_i = 0; inj_mask_i = '0;
`endif
        clear_stim(); model_reset();
        rst = 1; drive();
        #12;
        check_all();
        chk("rst_sec_data", sec_data_o, 64'h0);
        @(posedge clk); #1 rst = 0;

        // 1: clean line
        s_valid = 1; s_addr = 16'h0010; s_d[0] = 32'hDEADBEEF; s_d[1] = 32'h12345678;
        cycle();
        clear_stim();
        chk("t1_data", sec_data_o, 64'h12345678_DEADBEEF);
        chk("t1_flags", 64'({single_err_o, double_err_o}), 64'h0);
        cycle();
        chk("t1_noreq", 64'(wb_req_o), 64'h0);

        // 2: bank1 bit 5 flipped
        s_valid = 1; s_addr = 16'h0040; f_d[1] = 32'h20;
        cycle();
        clear_stim();
        chk("t2_single", 64'(single_err_o), 64'h2);
        chk("t2_data", sec_data_o, 64'h12345678_DEADBEEF);
        cycle();
        chk("t2_req", 64'(wb_req_o), 64'h1);
        chk("t2_addr", 64'(wb_addr_o), 64'h0040);
        chk("t2_be", 64'(wb_be_o), 64'h2);
        chk("t2_ecc", 64'(wb_ecc_o), 64'({enc(32'h12345678), enc(32'hDEADBEEF)}));
        chk("t2_cnt", 64'(sec_cnt_o), 64'h1);
        gnt = 1; cycle(); gnt = 0;
        clr = 1; cycle(); clr = 0;

        // 3: bank0 double, bank1 single
        s_valid = 1; s_addr = 16'h0080; f_d[0] = 32'h208; f_d[1] = 32'h1;
        cycle();
        clear_stim();
        chk("t3_double", 64'(double_err_o), 64'h1);
        chk("t3_single", 64'(single_err_o), 64'h2);
        cycle();
        chk("t3_noreq", 64'(wb_req_o), 64'h0);
        chk("t3_ded", 64'(ded_cnt_o), 64'h1);
        chk("t3_sec", 64'(sec_cnt_o), 64'h1);

        // 4: fill, overflow, then push+pop at full
        for (int k = 0; k < 5; k++) begin sread(k % 2); cycle(); end
        clear_stim(); cycle(); cycle();
        chk("t4_full", 64'(wb_full_o), 64'h1);
        chk("t4_ovf", 64'(wb_ovf_o), 64'h1);
        clr = 1; cycle(); clr = 0;
        sread(0); cycle();
        clear_stim(); gnt = 1; cycle();
        gnt = 0; cycle();
        chk("t4_full2", 64'(wb_full_o), 64'h1);
        chk("t4_noovf", 64'(wb_ovf_o), 64'h0);
        gnt = 1; for (int k = 0; k < 5; k++) cycle();
        gnt = 0;

        // 5: counter saturation, then clear beats same-cycle increment
        for (int k = 0; k < 20; k++) begin
            sread(k % 2); gnt = 1'($urandom); cycle();
        end
        clear_stim(); cycle();
        chk("t5_sat", 64'(sec_cnt_o), 64'hF);
        sread(1); cycle();
        clear_stim(); clr = 1; cycle(); clr = 0;
        chk("t5_clr", 64'(sec_cnt_o), 64'h0);
        gnt = 1; for (int k = 0; k < 5; k++) cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            clear_stim();
            s_valid = 1'($urandom); s_en = NB'($urandom); s_addr = AW'($urandom);
            s_dis = ($urandom_range(9, 0) == 0); clr = ($urandom_range(19, 0) == 0);
            gnt = ($urandom_range(2, 0) == 0);
            s_d[0] = $urandom; s_d[1] = $urandom;
            set_flips(0, int'($urandom_range(2, 0)));
            set_flips(1, int'($urandom_range(2, 0)));
            cycle();
        end

        // 6: reset with entries queued and grant active
        clear_stim(); gnt = 1; cycle();
        gnt = 0;
        for (int k = 0; k < 3; k++) begin sread(0); cycle(); end
        clear_stim(); cycle(); cycle();
        chk("t6_pre", 64'(wb_req_o), 64'h1);
        gnt = 1; drive();
        #2 rst = 1;
        #1 chk("t6_req", 64'(wb_req_o), 64'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1 rst = 0;
        clear_stim(); cycle(); cycle();
        chk("t6_empty", 64'(wb_req_o), 64'h0);

`ifdef EL2_LSU_ECC_ERR_INJECT_EN
        clear_stim();
        s_wr = {32'h0, 32'hCAFEF00D}; wr_data_i = s_wr;
        inj_en_i = 1; inj_mask_i = '0; inj_mask_i[0] = 1'b1;
        #1;
        rd_data_i = wr_data_o; rd_ecc_i = wr_ecc_o;
        rd_valid_i = 1; rd_bank_en_i = 2'b01; ecc_disable = 0;
        @(posedge clk); #1;
        inj_en_i = 0; rd_valid_i = 0;
        chk("inj_single", 64'(single_err_o), 64'h1);
        chk("inj_data", 64'(sec_data_o[31:0]), 64'hCAFEF00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
